// File: rtl/niosii_subsys_nios2_gen2_0_cpu_ocimem_ctrl_if.sv
// Avalon-MM slave bus for the OCI debug RAM as seen from the CPU.
//   master modport: drives address/read/write/writedata/byteenable/debugaccess,
//                   receives readdata/waitrequest.
//   slave modport : the opposite directions; used by the OCI memory controller.
interface niosii_subsys_nios2_gen2_0_cpu_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              debugaccess;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata, byteenable, debugaccess,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable, debugaccess,
    output readdata, waitrequest
  );
endinterface

// File: rtl/niosii_subsys_nios2_gen2_0_cpu_ocimem_ctrl.sv
// OCI debug memory controller (system-clock side of the Nios II debug slave).
// Executes JTAG address-load / read / write commands on a single-port debug
// RAM and shares that RAM with the CPU through an Avalon-MM slave port.
// JTAG always wins the RAM port; a colliding CPU request is stalled a cycle.
//   clk, reset_n           : system clock, async active-low reset
//   jdo                    : JTAG data word (addr at [17 +: ADDR_W], data [34:3])
//   take_action_ocimem_a   : load address, read if jdo[34]
//   take_no_action_ocimem_a: increment address, then read
//   take_action_ocimem_b   : write jdo[34:3], then increment address
//   bus                    : Avalon-MM slave (readdata registered, waitrequest comb)
//   MonDReg, MonAReg       : JTAG data / address registers
//   monitor_ready          : last JTAG command has completed
module niosii_subsys_nios2_gen2_0_cpu_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  niosii_subsys_nios2_gen2_0_cpu_ocimem_ctrl_if.slave bus,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready
);

  typedef enum logic {IDLE, CPU_RD} state_t;
  typedef enum logic {OWN_JTAG, OWN_CPU} owner_t;

  state_t            state_q, state_d;
  owner_t            rd_owner;
  logic              rd_valid;
  logic [ADDR_W-1:0] mon_areg;
  logic [31:0]       mon_hold, rd_hold;
  logic              ready_q;

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] ram_q;

  // Priority when the upstream guarantee is broken: b, then a, then no_action_a.
  logic sel_b, sel_a, sel_na, jtag_any, jtag_rd;
  assign sel_b    = take_action_ocimem_b;
  assign sel_a    = take_action_ocimem_a & ~take_action_ocimem_b;
  assign sel_na   = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign jtag_any = sel_b | sel_a | sel_na;
  assign jtag_rd  = (sel_a & jdo[34]) | sel_na;

  logic [ADDR_W-1:0] areg_inc, jtag_addr_next;
  assign areg_inc       = mon_areg + ADDR_W'(1);
  assign jtag_addr_next = sel_a ? jdo[17 +: ADDR_W] : areg_inc;

  // jdo bits outside the address and data fields carry nothing for this block.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // CPU FSM: a CPU request is only served in IDLE in a cycle with no JTAG strobe.
  logic cpu_rd, cpu_wr;
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cpu_rd  = 1'b0;
    cpu_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!jtag_any) begin
          if (bus.read) begin
            cpu_rd  = 1'b1;
            state_d = CPU_RD;
          end else if (bus.write) begin
            cpu_wr = 1'b1;
          end
        end
      end
      CPU_RD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.waitrequest = (state_q == IDLE) &
                           (bus.read | ((bus.read | bus.write) & jtag_any));

  // Single RAM port arbitration.
  logic              ram_we, ram_rd;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  always_comb begin
    ram_we    = 1'b0;
    ram_rd    = 1'b0;
    ram_be    = 4'h0;
    ram_wdata = '0;
    ram_addr  = mon_areg;
    if (sel_b) begin
      ram_we    = 1'b1;
      ram_be    = 4'hF;
      ram_wdata = jdo[34:3];
    end else if (jtag_rd) begin
      ram_rd   = 1'b1;
      ram_addr = jtag_addr_next;
    end else if (cpu_rd) begin
      ram_rd   = 1'b1;
      ram_addr = bus.address;
    end else if (cpu_wr && bus.debugaccess) begin
      ram_we    = 1'b1;
      ram_be    = bus.byteenable;
      ram_wdata = bus.writedata;
      ram_addr  = bus.address;
    end
  end

  // NOTE: the RAM array and its output register sit outside the reset domain;
  // resetting them would prevent mapping onto a block RAM. Visibility of a
  // stale ram_q is controlled by rd_valid, which is reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rd_valid <= 1'b0;
      rd_owner <= OWN_JTAG;
      mon_areg <= '0;
      mon_hold <= '0;
      rd_hold  <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_valid <= ram_rd;
      if (ram_rd) rd_owner <= jtag_rd ? OWN_JTAG : OWN_CPU;
      mon_hold <= MonDReg;
      rd_hold  <= bus.readdata;
      if (sel_b || sel_na) mon_areg <= areg_inc;
      else if (sel_a)      mon_areg <= jdo[17 +: ADDR_W];
      if (jtag_any) ready_q <= 1'b1;
    end
  end

  // The RAM output register is steered to whichever side owns the read in
  // flight; otherwise each side holds its last value.
  assign MonDReg       = (rd_valid && rd_owner == OWN_JTAG) ? ram_q : mon_hold;
  assign bus.readdata  = (rd_valid && rd_owner == OWN_CPU)  ? ram_q : rd_hold;
  assign MonAReg       = mon_areg;
  assign monitor_ready = ready_q & ~jtag_any;

endmodule

// File: tb/tb_niosii_subsys_nios2_gen2_0_cpu_ocimem_ctrl.sv
// Scoreboard testbench for the OCI debug memory controller. Stimulus tasks
// update a behavioural model (word array + address/data registers) and push
// expectations; a monitor pops them when the DUT completes a JTAG command or
// acknowledges a CPU request.
module tb_niosii_subsys_nios2_gen2_0_cpu_ocimem_ctrl;
  localparam int ADDR_W = 8;
  localparam int K_A = 0, K_NA = 1, K_B = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        act_a = 1'b0, noact_a = 1'b0, act_b = 1'b0;
  logic [31:0] mon_dreg;
  logic [7:0]  mon_areg;
  logic        monitor_ready;

  niosii_subsys_nios2_gen2_0_cpu_ocimem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  niosii_subsys_nios2_gen2_0_cpu_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (act_a),
    .take_no_action_ocimem_a (noact_a),
    .take_action_ocimem_b    (act_b),
    .bus                     (bus),
    .MonDReg                 (mon_dreg),
    .MonAReg                 (mon_areg),
    .monitor_ready           (monitor_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model.
  logic [31:0] m_mem [256];
  logic [7:0]  m_areg = '0;
  logic [31:0] m_dreg = '0;

  typedef struct { logic [7:0] areg; logic [31:0] dreg; } jexp_t;
  typedef struct { bit is_read; logic [31:0] data; int stalls; } cexp_t;
  jexp_t jq[$];
  cexp_t cq[$];

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input bit rd);
    logic [37:0] d;
    d = {$urandom, $urandom};
    d[24:17] = addr;
    d[34] = rd;
    return d;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] d;
    d = {$urandom, $urandom};
    d[34:3] = data;
    return d;
  endfunction

  task automatic model_jtag(input int kind, input logic [37:0] d);
    case (kind)
      K_A: begin
        m_areg = d[24:17];
        if (d[34]) m_dreg = m_mem[m_areg];
      end
      K_NA: begin
        m_areg = m_areg + 8'd1;
        m_dreg = m_mem[m_areg];
      end
      default: begin
        m_mem[m_areg] = d[34:3];
        m_areg = m_areg + 8'd1;
      end
    endcase
    jq.push_back('{areg: m_areg, dreg: m_dreg});
  endtask

  task automatic drive_strobe(input int kind, input logic [37:0] d);
    jdo     = d;
    act_a   = (kind == K_A);
    noact_a = (kind == K_NA);
    act_b   = (kind == K_B);
  endtask

  // Called at posedge+1; returns at the next posedge+1 with strobes low.
  task automatic jtag_issue(input int kind, input logic [37:0] d);
    model_jtag(kind, d);
    drive_strobe(kind, d);
    @(posedge clk); #1;
    act_a = 1'b0; noact_a = 1'b0; act_b = 1'b0;
  endtask

  task automatic cpu_wait_accept();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!bus.waitrequest) done = 1;
    end
    if (!done) begin
      errors++;
      $display("FAIL cpu_accept_timeout: waitrequest stuck high at %0t", $time);
      if (cq.size() > 0) void'(cq.pop_front());
    end
    @(posedge clk); #1;
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic cpu_op(input bit is_read, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input bit dbg);
    if (is_read) begin
      cq.push_back('{is_read: 1'b1, data: m_mem[addr], stalls: 1});
    end else begin
      if (dbg) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m_mem[addr][8*i +: 8] = data[8*i +: 8];
      end
      cq.push_back('{is_read: 1'b0, data: 32'h0, stalls: 0});
    end
    bus.address = addr; bus.writedata = data; bus.byteenable = be; bus.debugaccess = dbg;
    bus.read = is_read; bus.write = !is_read;
    cpu_wait_accept();
  endtask

  // Monitor: pops a JTAG expectation the cycle after each strobe, and a CPU
  // expectation when a request is acknowledged.
  bit prev_seen = 0;
  int stall_cnt = 0;
  always @(negedge clk) begin
    bit    seen_now;
    jexp_t je;
    cexp_t ce;
    seen_now = act_a | noact_a | act_b;
    if (!reset_n) begin
      prev_seen = 0;
      stall_cnt = 0;
    end else begin
      if (prev_seen) begin
        if (jq.size() == 0) begin
          errors++;
          $display("FAIL jtag_unexpected: no expectation queued at %0t", $time);
        end else begin
          je = jq.pop_front();
          check("MonAReg", {24'h0, mon_areg}, {24'h0, je.areg});
          check("MonDReg", mon_dreg, je.dreg);
        end
        check("monitor_ready", {31'h0, monitor_ready}, {31'h0, !seen_now});
      end
      prev_seen = seen_now;
      if (bus.read || bus.write) begin
        if (bus.waitrequest) stall_cnt++;
        else if (cq.size() == 0) begin
          errors++;
          $display("FAIL cpu_unexpected: ack with no expectation at %0t", $time);
        end else begin
          ce = cq.pop_front();
          if (ce.is_read) check("readdata", bus.readdata, ce.data);
          check("cpu_stall_cycles", stall_cnt, ce.stalls);
          stall_cnt = 0;
        end
      end else begin
        check("waitrequest_idle", {31'h0, bus.waitrequest}, 32'h0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_MonAReg"}, {24'h0, mon_areg}, 32'h0);
    check({tag, "_MonDReg"}, mon_dreg, 32'h0);
    check({tag, "_readdata"}, bus.readdata, 32'h0);
    check({tag, "_monitor_ready"}, {31'h0, monitor_ready}, 32'h0);
    check({tag, "_waitrequest"}, {31'h0, bus.waitrequest}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.byteenable = '0; bus.debugaccess = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");
    @(posedge clk); #1;

    // Prefill every word through continuous JTAG writes; MonAReg wraps to 0.
    jtag_issue(K_A, jdo_a(8'h00, 1'b0));
    for (int i = 0; i < 256; i++) jtag_issue(K_B, jdo_b($urandom));

    // JTAG write then read-back.
    jtag_issue(K_A, jdo_a(8'h10, 1'b0));
    jtag_issue(K_B, jdo_b(32'hDEADBEEF));
    jtag_issue(K_A, jdo_a(8'h10, 1'b1));

    // Address wrap.
    jtag_issue(K_A, jdo_a(8'hFF, 1'b0));
    jtag_issue(K_NA, jdo_a(8'h00, 1'b0));

    // Collision: CPU read of 0x10 in the same cycle as a JTAG write to 0x10.
    jtag_issue(K_A, jdo_a(8'h10, 1'b0));
    begin
      logic [37:0] d;
      d = jdo_b(32'h12345678);
      model_jtag(K_B, d);
      cq.push_back('{is_read: 1'b1, data: m_mem[8'h10], stalls: 2});
      drive_strobe(K_B, d);
      bus.address = 8'h10; bus.read = 1'b1; bus.write = 1'b0;
      @(posedge clk); #1;
      act_b = 1'b0;
      cpu_wait_accept();
    end

    // Write gating with debugaccess.
    jtag_issue(K_A, jdo_a(8'h20, 1'b0));
    jtag_issue(K_B, jdo_b(32'h55555555));
    cpu_op(1'b0, 8'h20, 32'hAAAAAAAA, 4'b0011, 1'b1);
    jtag_issue(K_A, jdo_a(8'h20, 1'b1));
    cpu_op(1'b0, 8'h20, 32'hAAAAAAAA, 4'b1111, 1'b0);
    cpu_op(1'b1, 8'h20, 32'h0, 4'h0, 1'b0);

    // Continuous JTAG reads from address 0.
    jtag_issue(K_A, jdo_a(8'h00, 1'b0));
    for (int i = 0; i < 8; i++) jtag_issue(K_NA, jdo_a(8'h00, 1'b0));

    // Randomised mix of JTAG and CPU traffic.
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 5))
        0: jtag_issue(K_A, jdo_a(8'($urandom), 1'($urandom)));
        1: jtag_issue(K_NA, jdo_a(8'($urandom), 1'b0));
        2: jtag_issue(K_B, jdo_b($urandom));
        3: cpu_op(1'b1, 8'($urandom), 32'h0, 4'h0, 1'b0);
        4: cpu_op(1'b0, 8'($urandom), $urandom, 4'($urandom), 1'($urandom));
        default: begin @(posedge clk); #1; end
      endcase
    end

    // Reset in the middle of a CPU read: data must never appear afterwards.
    jtag_issue(K_A, jdo_a(8'h10, 1'b1));
    bus.address = 8'h20; bus.read = 1'b1; bus.write = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.read = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_read_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_areg = '0;
    m_dreg = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("after_abort");
    @(posedge clk); #1;

    // Memory survives reset.
    jtag_issue(K_A, jdo_a(8'h20, 1'b1));
    cpu_op(1'b1, 8'h10, 32'h0, 4'h0, 1'b0);

    repeat (3) @(negedge clk);
    check("jtag_queue_drained", jq.size(), 32'h0);
    check("cpu_queue_drained", cq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/niosii_subsys_nios2_gen2_0_cpu_ocimem_ctrl.md
# niosii_subsys_nios2_gen2_0_cpu_ocimem_ctrl

On-chip-instrumentation (OCI) debug memory controller on the system-clock side of the Nios II debug slave. It consumes the decoded JTAG command strobes and the 38-bit `jdo` data word from the debug-slave sysclk stage. It executes address-load, read and write operations on a single-port debug RAM, and returns read data and status on `MonDReg` and `monitor_ready` to the debug-slave TCK stage. The same RAM is also exposed to the CPU through an Avalon-MM slave port; JTAG accesses take priority.

## Interface
- `ADDR_W`, 8: debug RAM word-address width, legal range 4..12; depth is 2^ADDR_W 32-bit words.
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `jdo`  in  38  JTAG data word from the debug-slave sysclk stage.
- `take_action_ocimem_a`  in  1  one-cycle strobe: load address, optionally read.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: increment address, then read.
- `take_action_ocimem_b`  in  1  one-cycle strobe: write, then increment address.
- `address`  in  ADDR_W  Avalon word address.
- `read`  in  1  Avalon read request.
- `write`  in  1  Avalon write request.
- `writedata`  in  32  Avalon write data.
- `byteenable`  in  4  Avalon byte enables.
- `debugaccess`  in  1  CPU write qualifier; CPU writes are honoured only when this is 1.
- `readdata`  out  32  Avalon read data, registered.
- `waitrequest`  out  1  Avalon stall.
- `MonDReg`  out  32  monitor data register returned to JTAG.
- `MonAReg`  out  ADDR_W  current JTAG word address.
- `monitor_ready`  out  1  high once the last JTAG command has completed.

## Operation
- **Strobes.** At most one JTAG strobe is active per cycle; the upstream stage guarantees this. If more than one is high, priority is ocimem_b, then action_a, then no_action_a.
- **take_action_ocimem_a.**
  - Sets `MonAReg <= jdo[17 +: ADDR_W]`.
  - If `jdo[34]`=1, issues a RAM read at the new address; `MonDReg` loads the RAM output one cycle later.
  - If `jdo[34]`=0, only the address loads.
- **take_no_action_ocimem_a.** Sets `MonAReg <= MonAReg+1` and issues a read at the incremented address. `MonDReg` loads one cycle later.
- **take_action_ocimem_b.** Writes `jdo[34:3]` to `mem[MonAReg]` with all byte lanes enabled. `MonAReg` then increments.
- **Address wrap.** `MonAReg` increments modulo 2^ADDR_W, so 2^ADDR_W−1 wraps to 0.
- **monitor_ready.**
  - Cleared in the cycle of any JTAG strobe.
  - Set the next cycle for writes and address-only loads.
  - Set in the same cycle `MonDReg` loads for reads.
- **RAM.** Single-port, synchronous read with 1-cycle latency and byte-enabled writes. A read-owner flag (JTAG or CPU) steers the RAM output to `MonDReg` or `readdata`.
- **CPU FSM.** Two states, IDLE and CPU_RD.
  - IDLE with `read`=1 and no JTAG strobe: issue the RAM read, hold `waitrequest`=1, go to CPU_RD.
  - CPU_RD: `readdata` holds valid RAM output and `waitrequest`=0; return to IDLE.
  - IDLE with `write`=1 and no JTAG strobe: `waitrequest`=0 and the write completes this cycle. RAM is written only if `debugaccess`=1; otherwise the write is silently dropped but still acknowledged.
  - Any JTAG strobe in IDLE stalls a CPU request (`waitrequest`=1) for that cycle; the request retries the next cycle.
  - A JTAG strobe in CPU_RD is accepted, since the RAM port is free; the CPU read completes normally.
- **waitrequest** (combinational) = (`read` & state==IDLE) | ((`read`|`write`) & any JTAG strobe & state==IDLE). It is 0 when there is no request.
- **Reset values.**
  - `MonAReg`=0, `MonDReg`=0, `readdata`=0, `monitor_ready`=0.
  - FSM in IDLE, read-owner flag cleared.
  - RAM contents are not reset.
- **Reset mid-operation.** An in-flight read is abandoned; no `MonDReg` or `readdata` update occurs after reset release.

## Timing
- JTAG read: strobe at cycle N. `MonDReg` and `monitor_ready`=1 are visible at N+1 after the clock edge.
- JTAG write: strobe at N. RAM is updated at the N edge, `MonAReg`+1 at N+1, and `monitor_ready`=1 at N+1.
- CPU read: 2-cycle minimum, with `waitrequest` high in cycle 1 and low in cycle 2. Each colliding JTAG strobe adds one cycle.
- CPU write: 1 cycle when uncontested.
- Back-to-back JTAG strobes every cycle are supported at full rate.

## Test plan
- **Reset:** assert `reset_n`=0 mid CPU read → all outputs 0, `waitrequest`=0 with `read` low, FSM IDLE.
- **JTAG write then read-back:**
  - action_a with jdo address 0x10 and jdo[34]=0, then ocimem_b with data 0xDEADBEEF → mem[0x10]=0xDEADBEEF, `MonAReg`=0x11.
  - action_a address 0x10 with jdo[34]=1 → `MonDReg`=0xDEADBEEF, `monitor_ready`=1 one cycle after the strobe.
- **Wrap:** `MonAReg`=0xFF, then no_action_a → `MonAReg`=0x00 and `MonDReg`=mem[0].
- **Collision:** CPU `read` of 0x10 in the same cycle as ocimem_b writing 0x12345678 to 0x10 → `waitrequest` is high for 2 cycles, then `readdata`=0x12345678.
- **Write gating:** CPU write of 0xAAAAAAAA with byteenable 4'b0011 to 0x20 (pre-filled 0x55555555) → with `debugaccess`=1 mem=0x5555AAAA; with `debugaccess`=0 the value is unchanged and `waitrequest`=0 in both cases.
- **Continuous JTAG:** 8 consecutive no_action_a strobes from address 0 → `MonDReg` sequences mem[1..8], one word per cycle, with no stall.
